// File: rtl/hazard_pipe_pkg.sv
// rtl/hazard_pipe_pkg.sv - shared types and constants for the hazard pipeline
// Holds the FSM states, the bypass-word field map and the bubble word.
package hazard_pipe_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_e;

  // Bypass-word field positions
  localparam int RA_LSB  = 0;
  localparam int RA_MSB  = 4;
  localparam int RB_LSB  = 5;
  localparam int RB_MSB  = 9;
  localparam int RD_LSB  = 10;
  localparam int RD_MSB  = 14;
  localparam int LW_BIT  = 29;
  localparam int SW_BIT  = 30;
  localparam int W30_BIT = 31;

  // regtowrite=0 in the bubble, so it can never match a bypass source
  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hazard_pipe_bypass_latch_reg.sv
// rtl/hazard_pipe_bypass_latch_reg.sv - 32-bit bypass latch with enable and bubble-load
// Bubble-load wins over enable; with neither asserted the latch holds.
module bypass_latch_reg
  import hazard_pipe_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        en,
  input  logic        bubble,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  always_comb begin
    q_d = q_q;
    if (bubble) begin
      q_d = BUBBLE;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q_q <= BUBBLE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hazard_pipe.sv
// rtl/hazard_pipe.sv - pipeline hazard controller driving the D/X, X/M, M/W bypass latches
// Handles load-use stalls, taken-branch flushes and multdiv wait with a saturating stall counter.
module hazard_pipe
  import hazard_pipe_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] dec_info,
  input  logic        stall_ld,
  input  logic        br_taken,
  input  logic        md_start,
  input  logic        md_ready,
  output logic [31:0] DXB,
  output logic [31:0] XMB,
  output logic [31:0] MWB,
  output logic        pc_en,
  output logic        fd_en,
  output logic        fd_flush,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic advance;
  logic flush;
  logic dx_en, dx_bub;
  logic xm_en, xm_bub;
  logic mw_en, mw_bub;

  always_comb begin
    state_d = state_q;
    advance = 1'b1;
    flush   = 1'b0;
    dx_en   = 1'b1;
    dx_bub  = 1'b0;
    xm_en   = 1'b1;
    xm_bub  = 1'b0;
    mw_en   = 1'b1;
    mw_bub  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (br_taken) begin
          flush  = 1'b1;
          dx_bub = 1'b1;
        end else if (md_start) begin
          // Simultaneous md_ready means the result is already there: no wait.
          if (!md_ready) begin
            state_d = ST_MD_WAIT;
          end
        end else if (stall_ld) begin
          advance = 1'b0;
          dx_en   = 1'b0;
          xm_bub  = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        if (md_ready) begin
          state_d = ST_RUN;
        end else begin
          advance = 1'b0;
          dx_en   = 1'b0;
          xm_en   = 1'b0;
          mw_bub  = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!advance && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  bypass_latch_reg u_dx (
    .clock  (clock),
    .resetn (resetn),
    .en     (dx_en),
    .bubble (dx_bub),
    .d      (dec_info),
    .q      (DXB)
  );

  bypass_latch_reg u_xm (
    .clock  (clock),
    .resetn (resetn),
    .en     (xm_en),
    .bubble (xm_bub),
    .d      (DXB),
    .q      (XMB)
  );

  bypass_latch_reg u_mw (
    .clock  (clock),
    .resetn (resetn),
    .en     (mw_en),
    .bubble (mw_bub),
    .d      (XMB),
    .q      (MWB)
  );

  // Enables and flush are forced low while reset is held.
  assign pc_en     = advance & resetn;
  assign fd_en     = advance & resetn;
  assign fd_flush  = flush & resetn;
  assign md_busy   = (state_q == ST_MD_WAIT);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_pipe.sv
// tb/tb_hazard_pipe.sv - scoreboard testbench for hazard_pipe
// Stimulus queues hand-computed expectations; a monitor pops and compares each cycle.
module tb_hazard_pipe;

  logic        clock;
  logic        resetn;
  logic [31:0] dec_info;
  logic        stall_ld;
  logic        br_taken;
  logic        md_start;
  logic        md_ready;
  logic [31:0] DXB, XMB, MWB;
  logic        pc_en, fd_en, fd_flush, md_busy;
  logic [15:0] stall_cnt;

  hazard_pipe dut (
    .clock     (clock),
    .resetn    (resetn),
    .dec_info  (dec_info),
    .stall_ld  (stall_ld),
    .br_taken  (br_taken),
    .md_start  (md_start),
    .md_ready  (md_ready),
    .DXB       (DXB),
    .XMB       (XMB),
    .MWB       (MWB),
    .pc_en     (pc_en),
    .fd_en     (fd_en),
    .fd_flush  (fd_flush),
    .md_busy   (md_busy),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic [31:0] dxb;
    logic [31:0] xmb;
    logic [31:0] mwb;
    logic        pc;
    logic        flush;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: inputs driven after the falling edge, comb outputs expected
  // during this cycle, register values expected after the next rising edge.
  task automatic step(input logic [31:0] dec, input logic st, input logic br,
                      input logic ms, input logic mr,
                      input logic [31:0] e_dx, input logic [31:0] e_xm, input logic [31:0] e_mw,
                      input logic e_pc, input logic e_fl, input logic e_busy,
                      input logic [15:0] e_cnt);
    exp_t e;
    @(negedge clock);
    dec_info = dec;
    stall_ld = st;
    br_taken = br;
    md_start = ms;
    md_ready = mr;
    e.dxb = e_dx; e.xmb = e_xm; e.mwb = e_mw;
    e.pc = e_pc; e.flush = e_fl; e.busy = e_busy; e.cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t cur;
    bit   have;
    forever begin
      @(negedge clock);
      #2;
      have = 0;
      if (exp_q.size() > 0) begin
        cur  = exp_q.pop_front();
        have = 1;
        chk("pc_en", {31'b0, pc_en}, {31'b0, cur.pc});
        chk("fd_en", {31'b0, fd_en}, {31'b0, cur.pc});
        chk("fd_flush", {31'b0, fd_flush}, {31'b0, cur.flush});
        chk("md_busy", {31'b0, md_busy}, {31'b0, cur.busy});
      end
      @(posedge clock);
      #1;
      if (have) begin
        chk("DXB", DXB, cur.dxb);
        chk("XMB", XMB, cur.xmb);
        chk("MWB", MWB, cur.mwb);
        chk("stall_cnt", {16'b0, stall_cnt}, {16'b0, cur.cnt});
      end
    end
  end

  initial begin : stimulus
    bit drained;
    dec_info = 32'h0; stall_ld = 0; br_taken = 0; md_start = 0; md_ready = 0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("rst_DXB", DXB, 32'h0);
    chk("rst_XMB", XMB, 32'h0);
    chk("rst_MWB", MWB, 32'h0);
    chk("rst_cnt", {16'b0, stall_cnt}, 32'h0);
    chk("rst_pc_en", {31'b0, pc_en}, 32'h0);
    chk("rst_md_busy", {31'b0, md_busy}, 32'h0);
    @(negedge clock);
    resetn = 1'b1;

    // straight-line ALU flow
    step(32'h0000_0421, 0,0,0,0, 32'h0000_0421, 32'h0,         32'h0,         1,0,0, 16'd0);
    step(32'h0000_0842, 0,0,0,0, 32'h0000_0842, 32'h0000_0421, 32'h0,         1,0,0, 16'd0);
    step(32'h0000_0C63, 0,0,0,0, 32'h0000_0C63, 32'h0000_0842, 32'h0000_0421, 1,0,0, 16'd0);
    step(32'h2000_0C22, 0,0,0,0, 32'h2000_0C22, 32'h0000_0C63, 32'h0000_0842, 1,0,0, 16'd0);
    // load-use stall
    step(32'h0000_1111, 1,0,0,0, 32'h2000_0C22, 32'h0,         32'h0000_0C63, 0,0,0, 16'd1);
    step(32'h0000_1111, 0,0,0,0, 32'h0000_1111, 32'h2000_0C22, 32'h0,         1,0,0, 16'd1);
    // branch beats stall
    step(32'h0000_2222, 1,1,0,0, 32'h0,         32'h0000_1111, 32'h2000_0C22, 1,1,0, 16'd1);
    step(32'h0000_0C63, 0,0,0,0, 32'h0000_0C63, 32'h0,         32'h0000_1111, 1,0,0, 16'd1);
    // multdiv with 5 wait cycles; events inside the wait are ignored
    step(32'h0000_3333, 0,0,1,0, 32'h0000_3333, 32'h0000_0C63, 32'h0,         1,0,0, 16'd1);
    step(32'h0000_4444, 0,0,0,0, 32'h0000_3333, 32'h0000_0C63, 32'h0,         0,0,1, 16'd2);
    step(32'h0000_4444, 0,1,0,0, 32'h0000_3333, 32'h0000_0C63, 32'h0,         0,0,1, 16'd3);
    step(32'h0000_4444, 1,0,0,0, 32'h0000_3333, 32'h0000_0C63, 32'h0,         0,0,1, 16'd4);
    step(32'h0000_4444, 0,0,1,0, 32'h0000_3333, 32'h0000_0C63, 32'h0,         0,0,1, 16'd5);
    step(32'h0000_4444, 0,0,0,0, 32'h0000_3333, 32'h0000_0C63, 32'h0,         0,0,1, 16'd6);
    step(32'h0000_4444, 0,0,0,1, 32'h0000_4444, 32'h0000_3333, 32'h0000_0C63, 1,0,1, 16'd6);
    step(32'h0000_5555, 0,0,0,0, 32'h0000_5555, 32'h0000_4444, 32'h0000_3333, 1,0,0, 16'd6);
    // zero-wait multdiv
    step(32'h0000_6666, 0,0,1,1, 32'h0000_6666, 32'h0000_5555, 32'h0000_4444, 1,0,0, 16'd6);
    step(32'h0000_7777, 0,0,0,0, 32'h0000_7777, 32'h0000_6666, 32'h0000_5555, 1,0,0, 16'd6);
    // reset in the middle of a multdiv wait
    step(32'h0000_0421, 0,0,1,0, 32'h0000_0421, 32'h0000_7777, 32'h0000_6666, 1,0,0, 16'd6);
    step(32'h0000_0421, 0,0,0,0, 32'h0000_0421, 32'h0000_7777, 32'h0,         0,0,1, 16'd7);
    @(negedge clock);
    #3;
    dec_info = 32'h0; md_start = 0; md_ready = 0; stall_ld = 0;
    br_taken = 1'b1;
    resetn   = 1'b0;
    #1;
    chk("mid_rst_DXB", DXB, 32'h0);
    chk("mid_rst_XMB", XMB, 32'h0);
    chk("mid_rst_cnt", {16'b0, stall_cnt}, 32'h0);
    chk("mid_rst_md_busy", {31'b0, md_busy}, 32'h0);
    chk("mid_rst_fd_flush", {31'b0, fd_flush}, 32'h0);
    chk("mid_rst_pc_en", {31'b0, pc_en}, 32'h0);
    @(posedge clock);
    #1;
    chk("held_rst_MWB", MWB, 32'h0);
    chk("held_rst_md_busy", {31'b0, md_busy}, 32'h0);
    @(negedge clock);
    br_taken = 1'b0;
    resetn   = 1'b1;
    step(32'h0000_0842, 0,0,0,0, 32'h0000_0842, 32'h0,         32'h0,         1,0,0, 16'd0);
    step(32'h0000_0C63, 0,0,0,0, 32'h0000_0C63, 32'h0000_0842, 32'h0,         1,0,0, 16'd0);
    // drive the counter to 16'hFFFE through a long wait, then saturate
    step(32'h0,         0,0,1,0, 32'h0,         32'h0000_0C63, 32'h0000_0842, 1,0,0, 16'd0);
    for (int i = 0; i < 32'hFFFE; i++) begin
      step(32'h0, 0,0,0,0, 32'h0, 32'h0000_0C63, 32'h0, 0,0,1, 16'(i + 1));
    end
    step(32'h0,         0,0,0,0, 32'h0,         32'h0000_0C63, 32'h0,         0,0,1, 16'hFFFF);
    step(32'h0,         0,0,0,0, 32'h0,         32'h0000_0C63, 32'h0,         0,0,1, 16'hFFFF);
    step(32'h0,         0,0,0,0, 32'h0,         32'h0000_0C63, 32'h0,         0,0,1, 16'hFFFF);
    step(32'h0000_0421, 0,0,0,1, 32'h0000_0421, 32'h0,         32'h0000_0C63, 1,0,1, 16'hFFFF);
    step(32'h0000_0842, 0,0,0,0, 32'h0000_0842, 32'h0000_0421, 32'h0,         1,0,0, 16'hFFFF);

    drained = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      #3;
      if (exp_q.size() == 0) begin
        drained = 1;
        break;
      end
    end
    n_tests++;
    if (!drained) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clock);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
